i2c_target_regs: RTL and testbench

I2C responder (target) exposing a small byte-wide register file to an external or on-board I2C initiator, such as the SweRVolf I2C master on the Nexys A7 top level. It samples SCL/SDA in the core clock domain, decodes START/STOP, matches a 7-bit address and handles register-pointer writes, auto-incrementing data writes and reads. It drives SDA open-drain only, and the register contents are exported to fabric.

---
 rtl/i2c_target_regs_if.sv | 10 +
 rtl/i2c_target_regs.sv | 189 ++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regs_if.sv
// I2C pad-side bundle between an initiator (bus model or pad logic) and the target.
// The target only ever pulls SDA low through o_sda_oe; it never drives SCL.
interface i2c_target_regs_if;
    logic i_scl;
    logic i_sda;
    logic o_sda_oe;

    modport master (output i_scl, output i_sda, input o_sda_oe);
    modport slave  (input i_scl, input i_sda, output o_sda_oe);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS byte registers with pointer write, auto-increment write and read.
// Optional I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter after each synchronizer.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h3C,
    parameter int         NUM_REGS    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    i2c_target_regs_if.slave            bus,
    output logic [NUM_REGS*8-1:0]       o_regs,
    output logic                        o_wr_stb,
    output logic [$clog2(NUM_REGS)-1:0] o_wr_idx,
    output logic                        o_busy
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE
    } state_t;

    // Synchronizers reset to the idle-bus level so reset release creates no false edge.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f;

    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], bus.i_scl};
            sda_sync <= {sda_sync[0], bus.i_sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end

    assign scl_f = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
    assign sda_f = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    logic scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  =  scl_f & ~scl_q;
    assign scl_fall  = ~scl_f &  scl_q;
    assign start_det =  scl_f &  scl_q &  sda_q & ~sda_f;
    assign stop_det  =  scl_f &  scl_q & ~sda_q &  sda_f;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    byte_in;
    logic [PW-1:0] ptr;
    logic          rw;
    logic          sda_oe;
    logic [7:0]    regs_q [NUM_REGS];

    assign byte_in = {shreg[6:0], sda_f};

    // NOTE: the register file is reset like any other flop because its cleared value is visible on o_regs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            o_wr_stb <= 1'b0;
            o_wr_idx <= '0;
            o_busy   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            scl_q    <= scl_f;
            sda_q    <= sda_f;
            o_wr_stb <= 1'b0;
            // Bus conditions win over bit sampling in the same cycle.
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (state == ADDR) begin
                                    if (byte_in[7:1] == TARGET_ADDR) begin
                                        o_busy <= 1'b1;
                                        rw     <= byte_in[0];
                                        state  <= ADDR_ACK;
                                    end else begin
                                        o_busy <= 1'b0;
                                        state  <= IGNORE;
                                    end
                                end else if (state == PTR) begin
                                    ptr   <= byte_in[PW-1:0];
                                    state <= PTR_ACK;
                                end else begin
                                    regs_q[ptr] <= byte_in;
                                    o_wr_stb    <= 1'b1;
                                    o_wr_idx    <= ptr;
                                    ptr         <= ptr + 1'b1;
                                    state       <= WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First fall after bit 8 pulls SDA; the next fall ends the ACK bit.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (state == ADDR_ACK && rw) begin
                                shreg   <= {regs_q[ptr][6:0], 1'b0};
                                sda_oe  <= ~regs_q[ptr][7];
                                bit_cnt <= '0;
                                state   <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                ptr     <= ptr + 1'b1;
                                bit_cnt <= '0;
                                state   <= RACK_WAIT;
                            end else begin
                                sda_oe <= ~shreg[7];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    RACK_WAIT: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                shreg   <= regs_q[ptr];
                                bit_cnt <= '0;
                                state   <= RDATA;
                            end else begin
                                o_busy <= 1'b0;
                                state  <= IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_sda_oe = sda_oe;

    // NOTE: combinational outputs get a full default first so no latch can be inferred.
    always_comb begin
        o_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) o_regs[8*i +: 8] = regs_q[i];
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C initiator with a wired-AND SDA line.
// Expected values are hand-computed per transaction.
module tb_i2c_target_regs;
    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m, sda_m;
    logic [31:0] regs;
    logic        wr_stb;
    logic [1:0]  wr_idx;
    logic        busy;

    always #5 clk = ~clk;

    i2c_target_regs_if bus ();
    assign bus.i_scl = scl_m;
    assign bus.i_sda = sda_m & ~bus.o_sda_oe;

    i2c_target_regs #(.TARGET_ADDR(7'h3C), .NUM_REGS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .o_regs   (regs),
        .o_wr_stb (wr_stb),
        .o_wr_idx (wr_idx),
        .o_busy   (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [1:0] wr_log[$];
    int         oe_cycles = 0;

    always @(negedge clk) begin
        if (wr_stb) wr_log.push_back(wr_idx);
        if (bus.o_sda_oe) oe_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = bus.i_sda; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bit_v);
            b[i] = bit_v;
        end
        write_bit(nack);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         n0, oe0;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        tick(5);
        check("rst_regs", regs, 32'h0);
        check("rst_oe", bus.o_sda_oe, 1'b0);
        check("rst_stb", wr_stb, 1'b0);
        check("rst_idx", wr_idx, 2'd0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(5);

        // Write reg1/reg2 through pointer 1.
        n0 = wr_log.size();
        i2c_start();
        write_byte(8'h78, ack); check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", busy, 1'b1);
        write_byte(8'h01, ack); check("wr_ptr_ack", ack, 1'b0);
        write_byte(8'hA5, ack); check("wr_d0_ack", ack, 1'b0);
        write_byte(8'h5A, ack); check("wr_d1_ack", ack, 1'b0);
        i2c_stop(); tick(4);
        check("wr_regs", regs, 32'h005A_A500);
        check("wr_stb_count", wr_log.size() - n0, 2);
        check("wr_idx0", wr_log[n0], 2'd1);
        check("wr_idx1", wr_log[n0+1], 2'd2);
        check("wr_busy_stop", busy, 1'b0);

        // Write wrapping from reg3 to reg0.
        n0 = wr_log.size();
        i2c_start();
        write_byte(8'h78, ack);
        write_byte(8'h03, ack);
        write_byte(8'hC3, ack);
        write_byte(8'h3C, ack); check("wrap_ack", ack, 1'b0);
        i2c_stop(); tick(4);
        check("wrap_regs", regs, 32'hC35A_A53C);
        check("wrap_idx0", wr_log[n0], 2'd3);
        check("wrap_idx1", wr_log[n0+1], 2'd0);

        // Pointer write, repeated START, two-byte read wrapping 3 -> 0.
        i2c_start();
        write_byte(8'h78, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'h79, ack); check("rd_addr_ack", ack, 1'b0);
        read_byte(1'b0, rd);    check("rd_byte0", rd, 8'hC3);
        check("rd_busy_mid", busy, 1'b1);
        read_byte(1'b1, rd);    check("rd_byte1", rd, 8'h3C);
        check("rd_busy_nack", busy, 1'b0);
        check("rd_oe_nack", bus.o_sda_oe, 1'b0);
        i2c_stop(); tick(4);

        // Read without a pointer write continues from pointer 1.
        i2c_start();
        write_byte(8'h79, ack);
        read_byte(1'b1, rd); check("rd_persist", rd, 8'hA5);
        i2c_stop(); tick(4);

        // Address mismatch: target stays off the bus.
        n0 = wr_log.size(); oe0 = oe_cycles;
        i2c_start();
        write_byte(8'h7A, ack); check("mis_ack", ack, 1'b1);
        check("mis_busy", busy, 1'b0);
        write_byte(8'h01, ack);
        write_byte(8'hFF, ack);
        i2c_stop(); tick(4);
        check("mis_oe_cycles", oe_cycles - oe0, 0);
        check("mis_regs", regs, 32'hC35A_A53C);
        check("mis_no_write", wr_log.size() - n0, 0);

        // STOP after 4 data bits aborts the byte.
        n0 = wr_log.size();
        i2c_start();
        write_byte(8'h78, ack);
        write_byte(8'h00, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop(); tick(4);
        check("abort_no_write", wr_log.size() - n0, 0);
        check("abort_oe", bus.o_sda_oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_regs", regs, 32'hC35A_A53C);
        i2c_start();
        write_byte(8'h78, ack);
        write_byte(8'h02, ack);
        write_byte(8'h77, ack); check("abort_next_ack", ack, 1'b0);
        i2c_stop(); tick(4);
        check("abort_next_regs", regs, 32'hC377_A53C);
        check("abort_next_idx", wr_log[wr_log.size()-1], 2'd2);

        // Reset while the target pulls SDA for bit 7 of reg2 (0x77).
        i2c_start();
        write_byte(8'h78, ack);
        write_byte(8'h02, ack);
        i2c_start();
        write_byte(8'h79, ack);
        check("rstrd_oe_before", bus.o_sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("rstrd_oe", bus.o_sda_oe, 1'b0);
        check("rstrd_regs", regs, 32'h0);
        check("rstrd_busy", busy, 1'b0);
        tick(3);
        rst = 1'b0;
        tick(3);
        i2c_stop(); tick(4);

        // Normal transaction after reset.
        n0 = wr_log.size();
        i2c_start();
        write_byte(8'h78, ack); check("post_addr_ack", ack, 1'b0);
        write_byte(8'h01, ack);
        write_byte(8'h99, ack);
        i2c_stop(); tick(4);
        check("post_regs", regs, 32'h0000_9900);
        check("post_idx", wr_log[n0], 2'd1);

        // 1-clk SCL high pulse during the low phase before address bit 7.
        i2c_start();
        sda_m = 1'b0; tick(2);
        scl_m = 1'b1; tick(1);
        scl_m = 1'b0; tick(2);
        write_byte(8'h78, ack);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        check("glitch_ack", ack, 1'b0);
        check("glitch_busy", busy, 1'b1);
`else
        check("glitch_ack", ack, 1'b1);
        check("glitch_busy", busy, 1'b0);
`endif
        i2c_stop(); tick(4);
        check("glitch_regs", regs, 32'h0000_9900);
        check("glitch_busy_stop", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
